clks_ctrl: RTL and testbench

Sequencing controller for the `clks` divider block. It owns the divider's `rst` and `enb` inputs and brings the divider up after a settle interval. It stops the divider only at a common phase boundary so `clk10`/`clk20`/`clk40` always halt low and aligned. It also publishes a mirrored phase count and per-rate single-cycle tick strobes so downstream serial/parallel logic can act on divided-clock edges without sampling the divided clocks themselves.

---
 rtl/clks_pkg.sv | 24 ++
 rtl/clks_phase.sv | 47 ++++
 rtl/clks_ctrl.sv | 110 +++++++++++
 tb/tb_clks_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/clks_pkg.sv
// Shared definitions for the clks divider, its sequencer and any consumer that
// aligns to divided-clock edges.
package clks_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RUN    = 2'd2,
      DRAIN  = 2'd3
   } clks_state_t;

   localparam int CLKS_PERIOD  = 8;
   localparam int CLKS_PHASE_W = 3;

   // A rate ticks on the last fast cycle before its divided clock rises.
   localparam logic [2:0] TICK40_MASK = 3'b001;
   localparam logic [2:0] TICK20_MASK = 3'b011;
   localparam logic [2:0] TICK10_MASK = 3'b111;

   function automatic logic tick_hit(input logic [2:0] ph, input logic [2:0] mask);
      return (ph & mask) == mask;
   endfunction

endpackage

// File: rtl/clks_phase.sv
// Mirrored phase counter of the clks divider with per-rate tick strobes.
// Ticks are registered from the next phase value so every output is a flop.
module clks_phase
   import clks_pkg::*;
#(
   parameter int PHASE_W = CLKS_PHASE_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               clr,
   output logic [PHASE_W-1:0] phase,
   output logic               tick40,
   output logic               tick20,
   output logic               tick10
);

   localparam logic [PHASE_W-1:0] M40 = PHASE_W'(TICK40_MASK);
   localparam logic [PHASE_W-1:0] M20 = PHASE_W'(TICK20_MASK);
   localparam logic [PHASE_W-1:0] M10 = PHASE_W'(TICK10_MASK);

   logic [PHASE_W-1:0] phase_nxt;

   always_comb begin
      phase_nxt = phase;
      if (clr) begin
         phase_nxt = '0;
      end else if (en) begin
         phase_nxt = phase + PHASE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase  <= '0;
         tick40 <= 1'b0;
         tick20 <= 1'b0;
         tick10 <= 1'b0;
      end else begin
         phase  <= phase_nxt;
         tick40 <= (phase_nxt & M40) == M40;
         tick20 <= (phase_nxt & M20) == M20;
         tick10 <= (phase_nxt & M10) == M10;
      end
   end

endmodule

// File: rtl/clks_ctrl.sv
// Sequencer for the clks divider: settle after reset release, run, and halt
// only at the end of a full period so all divided clocks stop low.
//
//   state  | meaning
//   IDLE   | divider held in reset, disabled
//   SETTLE | reset released, waiting SETTLE_CYC cycles before enable
//   RUN    | divider enabled, divided clocks valid (ready)
//   DRAIN  | stop accepted, running out the period until phase 7
module clks_ctrl
   import clks_pkg::*;
#(
   parameter int SETTLE_CYC = 4,
   parameter int PHASE_W    = CLKS_PHASE_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   output logic               divRst,
   output logic               divEnb,
   output logic               ready,
   output logic               busy,
   output logic [PHASE_W-1:0] phase,
   output logic               tick40,
   output logic               tick20,
   output logic               tick10
);

   localparam int                CNT_W       = $clog2(SETTLE_CYC + 1);
   localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

   clks_state_t      state, state_nxt;
   logic [CNT_W-1:0] settle_cnt, settle_cnt_nxt;
   logic             phase_end;
   logic             running, running_nxt;

   assign phase_end   = &phase;
   assign running     = (state == RUN) || (state == DRAIN);
   assign running_nxt = (state_nxt == RUN) || (state_nxt == DRAIN);

   always_comb begin
      state_nxt      = state;
      settle_cnt_nxt = settle_cnt;
      case (state)
         IDLE: begin
            settle_cnt_nxt = '0;
            if (start && !stop) begin
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            if (stop) begin
               state_nxt      = IDLE;
               settle_cnt_nxt = '0;
            end else if (settle_cnt == SETTLE_LAST) begin
               state_nxt      = RUN;
               settle_cnt_nxt = '0;
            end else begin
               settle_cnt_nxt = settle_cnt + CNT_W'(1);
            end
         end
         RUN: begin
            if (stop) begin
               state_nxt = phase_end ? IDLE : DRAIN;
            end
         end
         DRAIN: begin
            if (phase_end) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they never glitch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         settle_cnt <= '0;
         divRst     <= 1'b1;
         divEnb     <= 1'b0;
         ready      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         settle_cnt <= settle_cnt_nxt;
         divRst     <= (state_nxt == IDLE);
         divEnb     <= running_nxt;
         ready      <= (state_nxt == RUN);
         busy       <= (state_nxt != IDLE);
      end
   end

   clks_phase #(
      .PHASE_W (PHASE_W)
   ) u_phase (
      .clk    (clk),
      .rst    (rst),
      .en     (running),
      .clr    (!running_nxt),
      .phase  (phase),
      .tick40 (tick40),
      .tick20 (tick20),
      .tick10 (tick10)
   );

endmodule

// File: tb/tb_clks_ctrl.sv
// Directed bench for clks_ctrl: expected output vectors are queued as each
// step is driven and compared after the following clock edge.
module tb_clks_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       stop;
   logic       divRst, divEnb, ready, busy;
   logic [2:0] phase;
   logic       tick40, tick20, tick10;

   always #5 clk = ~clk;

   clks_ctrl #(
      .SETTLE_CYC (4),
      .PHASE_W    (3)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .stop   (stop),
      .divRst (divRst),
      .divEnb (divEnb),
      .ready  (ready),
      .busy   (busy),
      .phase  (phase),
      .tick40 (tick40),
      .tick20 (tick20),
      .tick10 (tick10)
   );

   logic [9:0] obs;
   assign obs = {divRst, divEnb, ready, busy, phase, tick40, tick20, tick10};

   int         checks   = 0;
   int         failures = 0;
   logic [9:0] exp_q[$];
   string      tag_q[$];

   // {divRst, divEnb, ready, busy, phase, tick40, tick20, tick10}
   function automatic logic [9:0] ev(input logic r, input logic e, input logic rd,
                                     input logic b, input logic [2:0] ph);
      return {r, e, rd, b, ph, ph[0], (ph[1:0] == 2'b11), (ph == 3'd7)};
   endfunction

   function automatic logic [9:0] v_idle();
      return ev(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
   endfunction
   function automatic logic [9:0] v_settle();
      return ev(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
   endfunction
   function automatic logic [9:0] v_run(input int ph);
      return ev(1'b0, 1'b1, 1'b1, 1'b1, 3'(ph));
   endfunction
   function automatic logic [9:0] v_drain(input int ph);
      return ev(1'b0, 1'b1, 1'b0, 1'b1, 3'(ph));
   endfunction

   task automatic check_pop();
      logic [9:0] e;
      string      t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (obs === e) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", t, obs, e);
      end
   endtask

   task automatic check_int(input string t, input int o, input int e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", t, o, e);
      end
   endtask

   task automatic step(input logic s, input logic p, input logic [9:0] e, input string t);
      start = s;
      stop  = p;
      exp_q.push_back(e);
      tag_q.push_back(t);
      @(posedge clk);
      #1;
      check_pop();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "bench timeout");
   end

   initial begin
      int n40, n20, n10;
      rst   = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back(v_idle()); tag_q.push_back("reset");
      check_pop();
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, v_idle(), "idle");

      // bring-up: divRst low after start edge, enable SETTLE_CYC edges later
      step(1'b1, 1'b0, v_settle(), "start_settle");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, v_settle(), "settle_hold");

      n40 = 0; n20 = 0; n10 = 0;
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 1'b0, v_run(i % 8), "run40");
         n40 += int'(tick40);
         n20 += int'(tick20);
         n10 += int'(tick10);
      end
      check_int("count_tick40", n40, 20);
      check_int("count_tick20", n20, 10);
      check_int("count_tick10", n10, 5);

      // stop at phase 2: drain through phase 7, then idle
      step(1'b1, 1'b0, v_run(0), "run_start_ignored");
      step(1'b0, 1'b0, v_run(1), "run_p1");
      step(1'b0, 1'b0, v_run(2), "run_p2");
      step(1'b0, 1'b1, v_drain(3), "stop_p2_drain");
      step(1'b1, 1'b1, v_drain(4), "drain_p4");
      step(1'b1, 1'b0, v_drain(5), "drain_start_ignored");
      step(1'b0, 1'b0, v_drain(6), "drain_p6");
      step(1'b0, 1'b0, v_drain(7), "drain_p7");
      step(1'b0, 1'b0, v_idle(), "drain_done_idle");

      // immediate restart, then stop sampled at phase 7 goes straight to idle
      step(1'b1, 1'b0, v_settle(), "restart_settle");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, v_settle(), "restart_hold");
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, v_run(i), "restart_run");
      step(1'b0, 1'b1, v_idle(), "stop_p7_direct");

      step(1'b1, 1'b1, v_idle(), "start_stop_idle");
      step(1'b1, 1'b1, v_idle(), "start_stop_idle2");

      // stop during settle
      step(1'b1, 1'b0, v_settle(), "settle_again");
      step(1'b0, 1'b0, v_settle(), "settle_again2");
      step(1'b0, 1'b1, v_idle(), "stop_in_settle");
      step(1'b0, 1'b0, v_idle(), "after_settle_stop");

      // async reset in the middle of a drain
      step(1'b1, 1'b0, v_settle(), "pre_rst_settle");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, v_settle(), "pre_rst_hold");
      step(1'b0, 1'b0, v_run(0), "pre_rst_p0");
      step(1'b0, 1'b0, v_run(1), "pre_rst_p1");
      step(1'b0, 1'b1, v_drain(2), "pre_rst_drain");
      #2;
      rst = 1'b0;
      #1;
      exp_q.push_back(v_idle()); tag_q.push_back("async_rst_drain");
      check_pop();
      @(negedge clk);
      rst  = 1'b1;
      stop = 1'b0;
      step(1'b0, 1'b0, v_idle(), "post_rst_idle");
      step(1'b1, 1'b0, v_settle(), "post_rst_settle");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, v_settle(), "post_rst_hold");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, v_run(i), "post_rst_run");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
